// File: rtl/psram_pkg.sv
// psram_pkg: command constants, FSM states and the in-page address step shared by the PSRAM link ends.
package psram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } psram_state_t;

    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam int         ADDR_BYTES = 3;

    // Increment inside a 2**page_aw page; bits above the page are held.
    function automatic logic [22:0] page_inc(input logic [22:0] a, input int page_aw);
        logic [22:0] m;
        m = (23'd1 << page_aw) - 23'd1;
        return (a & ~m) | ((a + 23'd1) & m);
    endfunction

endpackage

// File: rtl/psram_sync_edge.sv
// psram_sync_edge: 2-FF synchronizer for an asynchronous pin plus one-clk rise/fall pulses.
module psram_sync_edge (
    input  logic clk,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] meta_q;
    logic       prev_q;

    // No reset: the edge history keeps tracking the pin during reset, so a level
    // already present when reset releases does not look like a fresh edge.
    always_ff @(posedge clk) begin
        meta_q <= {meta_q[0], sig_i};
        prev_q <= meta_q[1];
    end

    assign rise_o = meta_q[1] & ~prev_q;
    assign fall_o = ~meta_q[1] & prev_q;

endmodule

// File: rtl/psram_responder.sv
// psram_responder: octal-SDR PSRAM device emulator backed by an inferred block RAM.
module psram_responder
    import psram_pkg::*;
#(
    parameter int MEM_AW     = 12,
    parameter int RD_LATENCY = 4,
    parameter int PAGE_AW    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_psram_cs,
    input  logic       i_psram_sclk,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_data_oe,
    output logic       o_busy,
    output logic       o_cmd_err
);

    logic               cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic [7:0]         data_meta_q, data_sync_q;
    psram_state_t       state_q, state_d;
    logic [22:0]        addr_q, addr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               rd_q, rd_d;
    logic [7:0]         dout_q, dout_d;
    logic               oe_q, oe_d;
    logic               err_q, err_d;
    logic               we;
    logic [7:0]         mem_q [2**MEM_AW];
    logic [7:0]         rdata_q;

    psram_sync_edge u_cs_sync (
        .clk    (clk),
        .sig_i  (i_psram_cs),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    psram_sync_edge u_sclk_sync (
        .clk    (clk),
        .sig_i  (i_psram_sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // Same two-stage delay as sclk, so data lines up with the sclk edge pulse.
    always_ff @(posedge clk) begin
        data_meta_q <= i_data;
        data_sync_q <= data_meta_q;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        dout_d  = dout_q;
        oe_d    = oe_q;
        err_d   = err_q;
        we      = 1'b0;
        if (cs_rise) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            dout_d  = 8'h00;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (cs_fall) state_d = ST_CMD;
                ST_CMD: if (sclk_rise) begin
                    rd_d    = data_sync_q == CMD_READ;
                    cnt_d   = 4'd0;
                    state_d = (data_sync_q == CMD_READ || data_sync_q == CMD_WRITE) ? ST_ADDR : ST_IGNORE;
                    err_d   = err_q | (state_d == ST_IGNORE);
                end
                ST_ADDR: if (sclk_rise) begin
                    addr_d = {addr_q[14:0], data_sync_q};
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'(ADDR_BYTES - 1)) begin
                        cnt_d   = 4'd0;
                        state_d = rd_q ? ST_DUMMY : ST_WDATA;
                    end
                end
                ST_DUMMY: if (sclk_rise) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(RD_LATENCY - 1)) begin
                        cnt_d   = 4'd0;
                        state_d = ST_RDATA;
                    end
                end
                ST_RDATA: if (sclk_fall) begin
                    dout_d = rdata_q;
                    oe_d   = 1'b1;
                    addr_d = page_inc(addr_q, PAGE_AW);
                end
                ST_WDATA: if (sclk_rise) begin
                    we     = 1'b1;
                    addr_d = page_inc(addr_q, PAGE_AW);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            dout_q  <= '0;
            oe_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            err_q   <= err_d;
        end
    end

    // Read port follows addr continuously; the dummy phase covers its one-clk latency.
    always_ff @(posedge clk) begin
        if (we && !reset) mem_q[addr_q[MEM_AW-1:0]] <= data_sync_q;
        rdata_q <= mem_q[addr_q[MEM_AW-1:0]];
    end

    assign o_data    = dout_q;
    assign o_data_oe = oe_q & ~cs_rise;
    assign o_busy    = state_q != ST_IDLE;
    assign o_cmd_err = err_q;

endmodule

// File: tb/tb_psram_responder.sv
// tb_psram_responder: table-driven frames plus hand sequences for abort and reset corner cases.
module tb_psram_responder;

    localparam int RDL = 4;

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          n;
        logic [31:0] d;
        logic        err;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, cs, sclk;
    logic [7:0] din, o_data;
    logic       oe, busy, err;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    psram_responder #(.MEM_AW(12), .RD_LATENCY(RDL), .PAGE_AW(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_psram_cs   (cs),
        .i_psram_sclk (sclk),
        .i_data       (din),
        .o_data       (o_data),
        .o_data_oe    (oe),
        .o_busy       (busy),
        .o_cmd_err    (err)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic sclk_cycle(input logic [7:0] b);
        din = b;
        tick(2);
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
        tick(4);
    endtask

    task automatic begin_frame(input logic [7:0] c, input logic [23:0] a);
        cs = 1'b0;
        tick(4);
        sclk_cycle(c);
        sclk_cycle(a[23:16]);
        sclk_cycle(a[15:8]);
        sclk_cycle(a[7:0]);
    endtask

    task automatic end_frame();
        cs = 1'b1;
        tick(6);
    endtask

    task automatic run_vec(input vec_t x);
        logic [7:0] b;
        begin_frame(x.cmd, x.addr);
        check("busy_open", {7'd0, busy}, 8'd1);
        if (x.cmd == 8'h03) begin
            repeat (RDL - 1) sclk_cycle(8'h00);
            check("oe_dummy", {7'd0, oe}, 8'd0);
            for (int i = 0; i < x.n; i++) begin
                b = 8'(x.d >> (24 - 8 * i));
                sclk_cycle(8'h00);
                check("rd_oe", {7'd0, oe}, 8'd1);
                check("rd_data", o_data, b);
            end
        end else begin
            for (int i = 0; i < x.n; i++) begin
                b = 8'(x.d >> (24 - 8 * i));
                sclk_cycle(b);
                check("wr_oe", {7'd0, oe}, 8'd0);
            end
        end
        end_frame();
        check("busy_close", {7'd0, busy}, 8'd0);
        check("oe_close", {7'd0, oe}, 8'd0);
        check("cmd_err", {7'd0, err}, {7'd0, x.err});
    endtask

    initial begin
        #500us;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v[12];
        vec_t t;
        logic saw;
        v[0]  = '{8'h02, 24'h00C000, 2, 32'hA55A0000, 1'b0};
        v[1]  = '{8'h03, 24'h00C000, 2, 32'hA55A0000, 1'b0};
        v[2]  = '{8'h02, 24'h000400, 1, 32'h77000000, 1'b0};
        v[3]  = '{8'h02, 24'h0003FF, 3, 32'h11223300, 1'b0};
        v[4]  = '{8'h03, 24'h0003FF, 3, 32'h11223300, 1'b0};
        v[5]  = '{8'h02, 24'h000400, 0, 32'h00000000, 1'b0};
        v[6]  = '{8'h03, 24'h000400, 1, 32'h77000000, 1'b0};
        v[7]  = '{8'h03, 24'h00C000, 2, 32'h22330000, 1'b0};
        v[8]  = '{8'h9F, 24'h0003FF, 1, 32'h99000000, 1'b1};
        v[9]  = '{8'h03, 24'hFF03FF, 1, 32'h11000000, 1'b1};
        v[10] = '{8'h02, 24'h801234, 1, 32'hC3000000, 1'b1};
        v[11] = '{8'h03, 24'h000234, 1, 32'hC3000000, 1'b1};

        reset = 1'b1;
        cs    = 1'b1;
        sclk  = 1'b0;
        din   = 8'h00;
        tick(5);
        reset = 1'b0;
        tick(2);
        check("rst_data", o_data, 8'h00);
        check("rst_oe", {7'd0, oe}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_err", {7'd0, err}, 8'd0);

        for (int k = 0; k < 12; k++) run_vec(v[k]);

        begin_frame(8'h03, 24'h00C000);
        saw = oe;
        repeat (2) begin
            sclk_cycle(8'h00);
            saw = saw | oe;
        end
        cs = 1'b1;
        repeat (10) begin
            tick(1);
            saw = saw | oe;
        end
        check("abort_oe", {7'd0, saw}, 8'd0);
        check("abort_busy", {7'd0, busy}, 8'd0);
        t = '{8'h02, 24'h000010, 1, 32'h5C000000, 1'b1};
        run_vec(t);
        t = '{8'h03, 24'h000010, 1, 32'h5C000000, 1'b1};
        run_vec(t);

        t = '{8'h02, 24'h000500, 3, 32'h10203000, 1'b1};
        run_vec(t);
        begin_frame(8'h02, 24'h000500);
        sclk_cycle(8'hE1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("mid_rst_busy", {7'd0, busy}, 8'd0);
        check("mid_rst_oe", {7'd0, oe}, 8'd0);
        check("mid_rst_data", o_data, 8'h00);
        check("mid_rst_err", {7'd0, err}, 8'd0);
        sclk_cycle(8'hEE);
        sclk_cycle(8'hEE);
        check("post_rst_busy", {7'd0, busy}, 8'd0);
        check("post_rst_err", {7'd0, err}, 8'd0);
        end_frame();
        t = '{8'h03, 24'h000500, 3, 32'hE1203000, 1'b0};
        run_vec(t);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
